tlb_ctrl: RTL and testbench

- Sequences software TLB maintenance (probe, indexed read, indexed write, random write) onto the shared rw/probe port of the 32-entry TLB.
- Sits between the control unit and the TLB replicas used by instruction fetch and data access; the write strobe fans out to all replicas.
- Owns the random replacement index.
- Accepts one command at a time over a valid/ready handshake and returns one response per command.

---
 rtl/tlb_ctrl_if.sv | 31 +++
 rtl/tlb_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ctrl_if.sv
// tlb_ctrl_if: command/response channel between the control unit and the
// TLB maintenance controller.
//   cmd_*  : one maintenance command (valid/ready), issued by the control unit
//   rsp_*  : one response per command (valid/ready), returned by the controller
// Modports:
//   master : control unit side (drives cmd_*, rsp_ready)
//   slave  : tlb_ctrl side (drives cmd_ready, rsp_*)
interface tlb_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_index;
   logic [19:0] cmd_page;
   logic [19:0] cmd_frame;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_miss;
   logic [4:0]  rsp_index;
   logic [19:0] rsp_page;
   logic [19:0] rsp_frame;

   modport master (
      output cmd_valid, cmd_op, cmd_index, cmd_page, cmd_frame, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_miss, rsp_index, rsp_page, rsp_frame
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_index, cmd_page, cmd_frame, rsp_ready,
      output cmd_ready, rsp_valid, rsp_miss, rsp_index, rsp_page, rsp_frame
   );
endinterface

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequences software TLB maintenance (probe, indexed read, indexed
// write, random write) onto the shared rw/probe port of the 32-entry TLB and
// owns the random replacement index.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : command/response channel (see tlb_ctrl_if)
//   random_index    : current random replacement counter (WIRED..31)
//   tlb_probe_*     : associative lookup port (page out, miss/found back)
//   tlb_rw_index    : index for TLB read/write port
//   tlb_w_*         : write strobe (fans out to all replicas) and write data
//   tlb_r_*         : registered read data, valid one cycle after index
module tlb_ctrl #(
   parameter int unsigned WIRED = 4
) (
   input  logic        clk,
   input  logic        rst,
   tlb_ctrl_if.slave   bus,
   output logic [4:0]  random_index,
   output logic [19:0] tlb_probe_page,
   input  logic        tlb_probe_miss,
   input  logic [4:0]  tlb_probe_found,
   output logic [4:0]  tlb_rw_index,
   output logic        tlb_w_enable,
   output logic [19:0] tlb_w_page,
   output logic [19:0] tlb_w_frame,
   input  logic [19:0] tlb_r_page,
   input  logic [19:0] tlb_r_frame
);

   localparam logic [4:0] WIRED_C = 5'(WIRED);

   localparam logic [1:0] OP_PROBE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_CAPT = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   state_t      state_r, state_nxt_s;
   logic        accept_s;
   logic [4:0]  acc_index_s;
   logic [4:0]  rand_r, rand_nxt_s;
   logic [1:0]  op_r;
   logic [4:0]  index_r;
   logic        cmd_ready_r, rsp_valid_r;
   logic        rsp_miss_r, rsp_miss_nxt_s;
   logic [4:0]  rsp_index_r, rsp_index_nxt_s;
   logic [19:0] rsp_page_r, rsp_page_nxt_s;
   logic [19:0] rsp_frame_r, rsp_frame_nxt_s;
   logic [19:0] probe_page_r;
   logic [4:0]  rw_index_r;
   logic        w_enable_r;
   logic [19:0] w_page_r, w_frame_r;

   // Next-state decode and acceptance of a new command
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            // Reads need one extra cycle for the registered TLB read data
            if (op_r == OP_READ) begin
               state_nxt_s = ST_CAPT;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         ST_CAPT: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Random write targets the counter value seen in the acceptance cycle
   always_comb begin
      acc_index_s = bus.cmd_index;
      if (bus.cmd_op == 2'b11) begin
         acc_index_s = rand_r;
      end else begin
         acc_index_s = bus.cmd_index;
      end
   end

   // Random counter next value: decrement, wrap from WIRED back to 31
   always_comb begin
      rand_nxt_s = rand_r - 5'd1;
      if (rand_r <= WIRED_C) begin
         rand_nxt_s = 5'd31;
      end else begin
         rand_nxt_s = rand_r - 5'd1;
      end
   end

   // Response capture: probe/write results at end of EXEC, read data at end of CAPT
   always_comb begin
      rsp_miss_nxt_s  = rsp_miss_r;
      rsp_index_nxt_s = rsp_index_r;
      rsp_page_nxt_s  = rsp_page_r;
      rsp_frame_nxt_s = rsp_frame_r;
      case (state_r)
         ST_EXEC: begin
            if (op_r == OP_PROBE) begin
               rsp_miss_nxt_s  = tlb_probe_miss;
               rsp_index_nxt_s = tlb_probe_miss ? 5'd0 : tlb_probe_found;
               rsp_page_nxt_s  = 20'd0;
               rsp_frame_nxt_s = 20'd0;
            end else if (op_r == OP_READ) begin
               rsp_miss_nxt_s  = rsp_miss_r;
               rsp_index_nxt_s = rsp_index_r;
               rsp_page_nxt_s  = rsp_page_r;
               rsp_frame_nxt_s = rsp_frame_r;
            end else begin
               rsp_miss_nxt_s  = 1'b0;
               rsp_index_nxt_s = index_r;
               rsp_page_nxt_s  = 20'd0;
               rsp_frame_nxt_s = 20'd0;
            end
         end
         ST_CAPT: begin
            rsp_miss_nxt_s  = 1'b0;
            rsp_index_nxt_s = index_r;
            rsp_page_nxt_s  = tlb_r_page;
            rsp_frame_nxt_s = tlb_r_frame;
         end
         default: begin
            rsp_miss_nxt_s  = rsp_miss_r;
            rsp_index_nxt_s = rsp_index_r;
            rsp_page_nxt_s  = rsp_page_r;
            rsp_frame_nxt_s = rsp_frame_r;
         end
      endcase
   end

   // FSM state register and registered handshake flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cmd_ready_r <= (state_nxt_s == ST_IDLE);
         rsp_valid_r <= (state_nxt_s == ST_RESP);
      end
   end

   // Free-running random replacement counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rand_r <= 5'd31;
      end else begin
         rand_r <= rand_nxt_s;
      end
   end

   // Latched command fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r    <= 2'b00;
         index_r <= 5'd0;
      end else if (accept_s) begin
         op_r    <= bus.cmd_op;
         index_r <= acc_index_s;
      end
   end

   // Response registers, held stable through RESP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_miss_r  <= 1'b0;
         rsp_index_r <= 5'd0;
         rsp_page_r  <= 20'd0;
         rsp_frame_r <= 20'd0;
      end else begin
         rsp_miss_r  <= rsp_miss_nxt_s;
         rsp_index_r <= rsp_index_nxt_s;
         rsp_page_r  <= rsp_page_nxt_s;
         rsp_frame_r <= rsp_frame_nxt_s;
      end
   end

   // TLB port drive: loaded at acceptance so the values are present during EXEC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         probe_page_r <= 20'd0;
         rw_index_r   <= 5'd0;
         w_enable_r   <= 1'b0;
         w_page_r     <= 20'd0;
         w_frame_r    <= 20'd0;
      end else begin
         // Probe page only changes when a new probe starts; otherwise it holds
         if (accept_s && (bus.cmd_op == OP_PROBE)) begin
            probe_page_r <= bus.cmd_page;
         end
         if (accept_s && (bus.cmd_op != OP_PROBE)) begin
            rw_index_r <= acc_index_s;
         end else if (state_nxt_s == ST_CAPT) begin
            rw_index_r <= rw_index_r;
         end else begin
            rw_index_r <= 5'd0;
         end
         // Write strobe lives for the single EXEC cycle of a write
         w_enable_r <= accept_s && bus.cmd_op[1];
         w_page_r   <= (accept_s && bus.cmd_op[1]) ? bus.cmd_page  : 20'd0;
         w_frame_r  <= (accept_s && bus.cmd_op[1]) ? bus.cmd_frame : 20'd0;
      end
   end

   assign bus.cmd_ready  = cmd_ready_r;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_miss   = rsp_miss_r;
   assign bus.rsp_index  = rsp_index_r;
   assign bus.rsp_page   = rsp_page_r;
   assign bus.rsp_frame  = rsp_frame_r;
   assign random_index   = rand_r;
   assign tlb_probe_page = probe_page_r;
   assign tlb_rw_index   = rw_index_r;
   assign tlb_w_enable   = w_enable_r;
   assign tlb_w_page     = w_page_r;
   assign tlb_w_frame    = w_frame_r;

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed self-checking bench for tlb_ctrl with a small
// behavioural 32-entry TLB model behind the probe and rw ports.
module tb_tlb_ctrl;
   localparam int WIRED = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  random_index;
   logic [19:0] tlb_probe_page;
   logic        tlb_probe_miss;
   logic [4:0]  tlb_probe_found;
   logic [4:0]  tlb_rw_index;
   logic        tlb_w_enable;
   logic [19:0] tlb_w_page, tlb_w_frame;
   logic [19:0] tlb_r_page, tlb_r_frame;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wcount = 0;

   logic [19:0] m_page  [32];
   logic [19:0] m_frame [32];
   logic        m_vld   [32];

   tlb_ctrl_if bus ();

   tlb_ctrl #(.WIRED(WIRED)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .random_index    (random_index),
      .tlb_probe_page  (tlb_probe_page),
      .tlb_probe_miss  (tlb_probe_miss),
      .tlb_probe_found (tlb_probe_found),
      .tlb_rw_index    (tlb_rw_index),
      .tlb_w_enable    (tlb_w_enable),
      .tlb_w_page      (tlb_w_page),
      .tlb_w_frame     (tlb_w_frame),
      .tlb_r_page      (tlb_r_page),
      .tlb_r_frame     (tlb_r_frame)
   );

   always #5 clk = ~clk;

   // TLB model: write on strobe, otherwise registered read of rw index
   always @(posedge clk) begin
      if (tlb_w_enable) begin
         m_page[tlb_rw_index]  <= tlb_w_page;
         m_frame[tlb_rw_index] <= tlb_w_frame;
         m_vld[tlb_rw_index]   <= 1'b1;
      end else begin
         tlb_r_page  <= m_page[tlb_rw_index];
         tlb_r_frame <= m_frame[tlb_rw_index];
      end
   end

   // Probe model: lowest matching entry wins; junk index on miss
   always_comb begin
      tlb_probe_miss  = 1'b1;
      tlb_probe_found = 5'd21;
      for (int i = 31; i >= 0; i--) begin
         if (m_vld[i] && (m_page[i] == tlb_probe_page)) begin
            tlb_probe_miss  = 1'b0;
            tlb_probe_found = 5'(i);
         end
      end
   end

   // Cycles since reset release, used to predict the random counter
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Count write strobes seen at clock edges
   always @(posedge clk) begin
      if (rst && tlb_w_enable) wcount <= wcount + 1;
   end

   function automatic logic [4:0] exp_rand();
      return 5'(31 - (cyc % (32 - WIRED)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic [4:0] idx,
                        input logic [19:0] page, input logic [19:0] frame);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_index = idx;
      bus.cmd_page  = page;
      bus.cmd_frame = frame;
   endtask

   task automatic finish_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rsp_done_ready", {31'd0, bus.cmd_ready}, 32'd1);
   endtask

   initial begin
      int w0;
      logic [4:0] ri;
      for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_index = 5'd0;
      bus.cmd_page  = 20'd0;
      bus.cmd_frame = 20'd0;
      bus.rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rand", 32'(random_index), 32'd31);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_wen", 32'(tlb_w_enable), 32'd0);
      chk("rst_rw_index", 32'(tlb_rw_index), 32'd0);
      chk("rst_probe_page", 32'(tlb_probe_page), 32'd0);
      chk("rst_rsp_index", 32'(bus.rsp_index), 32'd0);
      chk("rst_rsp_page", 32'(bus.rsp_page), 32'd0);
      rst = 1'b1;

      // Random counter sequence 31..4 then wrap to 31
      for (int k = 0; k <= 28; k++) begin
         chk("rand_seq", 32'(random_index), (k == 28) ? 32'd31 : 32'(31 - k));
         chk("idle_wen", 32'(tlb_w_enable), 32'd0);
         chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
         @(negedge clk);
      end

      // Write indexed idx=7
      w0 = wcount;
      drive(2'b10, 5'd7, 20'h12345, 20'h00ABC);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("wr_wen", 32'(tlb_w_enable), 32'd1);
      chk("wr_rw_index", 32'(tlb_rw_index), 32'd7);
      chk("wr_w_page", 32'(tlb_w_page), 32'h12345);
      chk("wr_w_frame", 32'(tlb_w_frame), 32'h00ABC);
      chk("wr_ready_busy", 32'(bus.cmd_ready), 32'd0);
      chk("wr_rsp_early", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk("wr_wen_off", 32'(tlb_w_enable), 32'd0);
      chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("wr_rsp_index", 32'(bus.rsp_index), 32'd7);
      chk("wr_rsp_miss", 32'(bus.rsp_miss), 32'd0);
      chk("wr_pulses", 32'(wcount - w0), 32'd1);
      chk("wr_rw_idle", 32'(tlb_rw_index), 32'd0);
      finish_rsp();

      // Read idx=7
      drive(2'b01, 5'd7, 20'h0, 20'h0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("rd_rw_index", 32'(tlb_rw_index), 32'd7);
      chk("rd_wen", 32'(tlb_w_enable), 32'd0);
      chk("rd_rsp_e1", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk("rd_rsp_e2", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_page", 32'(bus.rsp_page), 32'h12345);
      chk("rd_frame", 32'(bus.rsp_frame), 32'h00ABC);
      chk("rd_index", 32'(bus.rsp_index), 32'd7);
      finish_rsp();

      // Probe hit
      drive(2'b00, 5'd3, 20'h12345, 20'h0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("ph_probe_page", 32'(tlb_probe_page), 32'h12345);
      chk("ph_rsp_e1", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk("ph_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("ph_miss", 32'(bus.rsp_miss), 32'd0);
      chk("ph_index", 32'(bus.rsp_index), 32'd7);
      chk("ph_page", 32'(bus.rsp_page), 32'd0);
      finish_rsp();

      // Probe miss: found index forced to 0
      drive(2'b00, 5'd3, 20'h99999, 20'h0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("pm_miss", 32'(bus.rsp_miss), 32'd1);
      chk("pm_index", 32'(bus.rsp_index), 32'd0);
      finish_rsp();
      chk("pm_probe_hold", 32'(tlb_probe_page), 32'h99999);

      // Response held 10 cycles while a new command waits
      drive(2'b00, 5'd0, 20'h12345, 20'h0);
      @(negedge clk);
      drive(2'b10, 5'd12, 20'h0ABCD, 20'h00123);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_index", 32'(bus.rsp_index), 32'd7);
         chk("hold_miss", 32'(bus.rsp_miss), 32'd0);
         chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
         chk("hold_wen", 32'(tlb_w_enable), 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("held_cmd_idle", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("held_cmd_wen", 32'(tlb_w_enable), 32'd1);
      chk("held_cmd_idx", 32'(tlb_rw_index), 32'd12);
      @(negedge clk);
      chk("held_cmd_rsp", 32'(bus.rsp_index), 32'd12);
      @(negedge clk);
      bus.rsp_ready = 1'b0;

      // Write random accepted when random_index is 9
      for (int k = 0; k < 40; k++) begin
         if (exp_rand() == 5'd9) break;
         @(negedge clk);
      end
      chk("wr9_rand", 32'(random_index), 32'd9);
      drive(2'b11, 5'd2, 20'h55555, 20'h0AAAA);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("wr9_wen", 32'(tlb_w_enable), 32'd1);
      chk("wr9_idx", 32'(tlb_rw_index), 32'd9);
      @(negedge clk);
      chk("wr9_rsp_idx", 32'(bus.rsp_index), 32'd9);
      finish_rsp();

      // 200 random writes never land on wired entries
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ri = exp_rand();
         drive(2'b11, 5'd1, 20'(32'h40000 + n), 20'h0);
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         chk("rnd_wen", 32'(tlb_w_enable), 32'd1);
         chk("rnd_idx", 32'(tlb_rw_index), 32'(ri));
         chk("rnd_wired", 32'(tlb_rw_index >= 5'(WIRED)), 32'd1);
         @(negedge clk);
         chk("rnd_rsp_idx", 32'(bus.rsp_index), 32'(ri));
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end

      // Reset during write EXEC
      drive(2'b10, 5'd20, 20'h77777, 20'h01234);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("mr_wen_before", 32'(tlb_w_enable), 32'd1);
      w0 = wcount;
      #2 rst = 1'b0;
      #1;
      chk("mr_wen_drop", 32'(tlb_w_enable), 32'd0);
      chk("mr_rw_index", 32'(tlb_rw_index), 32'd0);
      chk("mr_rand", 32'(random_index), 32'd31);
      chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      chk("mr_no_pulse", 32'(wcount - w0), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
         chk("mr_ready", 32'(bus.cmd_ready), 32'd1);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
